animation_scheduler: RTL and testbench
======================================

Name: animation_scheduler

Overview:
Sits between the game/score logic and the LED animation block. Goal and win events arrive as one-cycle pulses, possibly back-to-back or while an animation is still playing. The animation block ignores triggers while it is running, so this block queues the events, prioritises wins, and issues exactly one trigger pulse per animation. It then holds off for that animation's full play time before issuing the next trigger.

Parameters:
DEPTH, 4, goal-event queue depth (power of two, 2..16)
GOAL_HOLD, 60, BALL_CLOCK cycles to hold off after issuing a goal trigger (covers 2 repetitions x 9 steps x 3 cycles plus margin)
WIN_HOLD, 72, BALL_CLOCK cycles to hold off after issuing a win trigger

Ports:
BALL_CLOCK  input  1  block clock, shared with the animation block
reset  input  1  asynchronous, active-high reset
goal_in_1  input  1  one-cycle pulse: player 1 scored
goal_in_2  input  1  one-cycle pulse: player 2 scored
win_in_1  input  1  one-cycle pulse: player 1 won
win_in_2  input  1  one-cycle pulse: player 2 won
new_game  input  1  one-cycle pulse: clear game_over and the queue
goal_player_1  output  1  one-cycle trigger to the animation block
goal_player_2  output  1  one-cycle trigger to the animation block
win_player_1  output  1  one-cycle trigger to the animation block
win_player_2  output  1  one-cycle trigger to the animation block
busy  output  1  high while in HOLD
queue_count  output  $clog2(DEPTH)+1  number of goal events currently queued
overflow  output  1  sticky; set when a goal event is dropped because the queue is full
game_over  output  1  high from win acceptance until new_game

Behaviour:
- Reset (async, active-high) values:
  - All outputs 0.
  - Queue empty, state IDLE, hold counter 0, pending-win register empty.
- Goal queue:
  - FIFO of 1-bit entries (0 = player 1, 1 = player 2), with wrap-around read/write pointers.
  - goal_in_1 and goal_in_2 in the same cycle: both enqueued, player 1 first.
  - Each entry that finds the queue full is dropped and sets overflow.
  - Enqueue and dequeue in the same cycle are allowed; count is unchanged.
  - Goal inputs are ignored while game_over = 1.
- Pending win:
  - First win_in_x pulse while game_over = 0 is latched (player id), sets game_over, and flushes the goal queue (count goes to 0 next cycle).
  - win_in_1 and win_in_2 together: player 1 wins.
  - Later win pulses are ignored until new_game.
  - A goal pulse in the same cycle as the accepted win is discarded.
- States:
  - IDLE: if a pending win exists -> ISSUE_WIN; else if queue non-empty -> ISSUE_GOAL; else stay.
  - ISSUE_GOAL (1 cycle): pop head; drive goal_player_1 or goal_player_2 high for this cycle; load counter = GOAL_HOLD-1 -> HOLD.
  - ISSUE_WIN (1 cycle): drive win_player_x; clear the pending win; load counter = WIN_HOLD-1 -> HOLD.
  - HOLD: busy = 1; decrement counter each cycle; at 0 -> IDLE.
- Latency:
  - Event pulse in cycle N with the block idle -> trigger in cycle N+2 (N+1 latch/enqueue, N+1 IDLE decision, N+2 ISSUE). Triggers are registered outputs.
  - Spacing between consecutive triggers = HOLD + 2 cycles.
- Preemption:
  - A win arriving during HOLD of a goal does not abort the hold.
  - The win is issued at the next IDLE, ahead of any queued goals (which are flushed anyway).
- new_game:
  - Clears game_over, overflow, queue and pending win.
  - Does not abort an ongoing HOLD.
  - If in the same cycle as a win pulse, new_game takes effect and the win is accepted afterwards (win sets game_over again).
- At most one trigger output is high in any cycle.
- The counter is wide enough for max(GOAL_HOLD, WIN_HOLD).

Test Plan:
- Reset mid-HOLD: assert reset at cycle 10 of a goal hold -> all outputs 0 immediately (async); no trigger after release until a new event.
- Single goal: goal_in_2 at cycle 5 -> goal_player_2 pulse at cycle 7, busy high cycles 8..67, queue_count 0.
- Burst with overflow (DEPTH=4): six goal_in_1 pulses on consecutive cycles while busy -> queue_count reaches 4, overflow=1; exactly 5 goal_player_1 triggers total (1 immediate + 4 queued), each spaced 62 cycles apart.
- Simultaneous goals: goal_in_1 and goal_in_2 in the same idle cycle -> goal_player_1 first, goal_player_2 exactly 62 cycles later.
- Win preempts queue: 3 goals queued during HOLD, then win_in_2 -> queue_count=0, game_over=1; win_player_2 issued at the first IDLE; later goal_in_1 is ignored (count stays 0).
- new_game: after a win, pulse new_game -> game_over=0, overflow=0; next goal_in_1 produces a trigger normally.

Source files
------------

// File: rtl/animation_scheduler_if.sv
// Event/trigger bundle between the game logic, the scheduler and the LED animation block.
// The scheduler itself sits on the slave side.
interface animation_scheduler_if #(
  parameter int DEPTH = 4
);
  logic                     goal_in_1;
  logic                     goal_in_2;
  logic                     win_in_1;
  logic                     win_in_2;
  logic                     new_game;
  logic                     goal_player_1;
  logic                     goal_player_2;
  logic                     win_player_1;
  logic                     win_player_2;
  logic                     busy;
  logic [$clog2(DEPTH):0]   queue_count;
  logic                     overflow;
  logic                     game_over;

  modport master (
    output goal_in_1, goal_in_2, win_in_1, win_in_2, new_game,
    input  goal_player_1, goal_player_2, win_player_1, win_player_2,
           busy, queue_count, overflow, game_over
  );

  modport slave (
    input  goal_in_1, goal_in_2, win_in_1, win_in_2, new_game,
    output goal_player_1, goal_player_2, win_player_1, win_player_2,
           busy, queue_count, overflow, game_over
  );
endinterface

// File: rtl/animation_scheduler.sv
// Queues goal/win pulses and issues one registered trigger per animation, then waits
// out that animation's play time before issuing the next one. Wins take priority.
module animation_scheduler #(
  parameter int DEPTH     = 4,
  parameter int GOAL_HOLD = 60,
  parameter int WIN_HOLD  = 72
) (
  input logic                   BALL_CLOCK,
  input logic                   reset,
  animation_scheduler_if.slave  bus
);

  localparam int PW       = $clog2(DEPTH);
  localparam int MAX_HOLD = (GOAL_HOLD > WIN_HOLD) ? GOAL_HOLD : WIN_HOLD;
  localparam int CW       = $clog2(MAX_HOLD + 1);

  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [CW-1:0] HOLD_ONE = 1;

  typedef enum logic [1:0] {IDLE, ISSUE_GOAL, ISSUE_WIN, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DEPTH-1:0]   mem_q, mem_d;
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]        count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               game_over_q, game_over_d;
  logic               win_valid_q, win_valid_d;
  logic               win_id_q, win_id_d;
  logic [3:0]         trig_q, trig_d;

  logic               win_accept;
  logic               flush;
  logic               goal_ok;
  logic [1:0]         goals;

  assign goals      = {bus.goal_in_2, bus.goal_in_1};
  assign win_accept = (bus.win_in_1 | bus.win_in_2) & (~game_over_q | bus.new_game);
  assign flush      = win_accept | bus.new_game;
  assign goal_ok    = ~game_over_q & ~win_accept;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_d       = mem_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    game_over_d = game_over_q;
    win_valid_d = win_valid_q;
    win_id_d    = win_id_q;
    trig_d      = 4'b0000;

    // A goal is not launched on a cycle that flushes the queue; the pending win follows next cycle.
    unique case (state_q)
      IDLE: begin
        if (win_valid_q) begin
          state_d = ISSUE_WIN;
          trig_d  = win_id_q ? 4'b1000 : 4'b0100;
        end else if (count_q != '0 && !flush) begin
          state_d = ISSUE_GOAL;
          trig_d  = mem_q[rd_q] ? 4'b0010 : 4'b0001;
        end
      end
      ISSUE_GOAL: begin
        cnt_d   = CW'(GOAL_HOLD - 1);
        state_d = HOLD;
      end
      ISSUE_WIN: begin
        cnt_d       = CW'(WIN_HOLD - 1);
        win_valid_d = 1'b0;
        state_d     = HOLD;
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - HOLD_ONE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
    end else if (state_q == ISSUE_GOAL && count_q != '0) begin
      rd_d    = rd_q + PTR_ONE;
      count_d = count_q - CNT_ONE;
    end

    if (bus.new_game) begin
      overflow_d  = 1'b0;
      game_over_d = 1'b0;
      win_valid_d = 1'b0;
    end

    if (win_accept) begin
      win_valid_d = 1'b1;
      win_id_d    = ~bus.win_in_1;
      game_over_d = 1'b1;
    end

    // Player 1 is enqueued before player 2; the pop above has already freed its slot.
    for (int i = 0; i < 2; i++) begin
      if (goal_ok && goals[i]) begin
        if (count_d == CNT_FULL) begin
          overflow_d = 1'b1;
        end else begin
          mem_d[wr_d] = (i == 1);
          wr_d        = wr_d + PTR_ONE;
          count_d     = count_d + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge BALL_CLOCK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      game_over_q <= 1'b0;
      win_valid_q <= 1'b0;
      win_id_q    <= 1'b0;
      trig_q      <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      game_over_q <= game_over_d;
      win_valid_q <= win_valid_d;
      win_id_q    <= win_id_d;
      trig_q      <= trig_d;
    end
  end

  assign bus.goal_player_1 = trig_q[0];
  assign bus.goal_player_2 = trig_q[1];
  assign bus.win_player_1  = trig_q[2];
  assign bus.win_player_2  = trig_q[3];
  assign bus.busy          = (state_q == HOLD);
  assign bus.queue_count   = count_q;
  assign bus.overflow      = overflow_q;
  assign bus.game_over     = game_over_q;

endmodule

// File: tb/tb_animation_scheduler.sv
// Directed scenarios plus a random phase, each cycle compared against a timestamp/queue model.
module tb_animation_scheduler;

  localparam int DEPTH     = 4;
  localparam int GOAL_HOLD = 60;
  localparam int WIN_HOLD  = 72;
  localparam int GAP       = GOAL_HOLD + 2;

  logic BALL_CLOCK = 1'b0;
  logic reset;

  animation_scheduler_if #(.DEPTH(DEPTH)) bus ();

  animation_scheduler #(
    .DEPTH(DEPTH), .GOAL_HOLD(GOAL_HOLD), .WIN_HOLD(WIN_HOLD)
  ) dut (
    .BALL_CLOCK(BALL_CLOCK),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 BALL_CLOCK = ~BALL_CLOCK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  bit         mq[$];
  bit         m_win_valid, m_win_id, m_game_over, m_overflow;
  int         m_free, m_last_issue;
  logic [3:0] m_trig;

  int         trig_cyc[$];
  logic [3:0] trig_kind[$];
  int         max_count;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_win_valid  = 0;
    m_win_id     = 0;
    m_game_over  = 0;
    m_overflow   = 0;
    m_free       = 0;
    m_last_issue = -1;
    m_trig       = 4'b0000;
  endtask

  // Advances the model over the current cycle given its input pulses.
  task automatic modelStep(input bit g1, input bit g2, input bit w1, input bit w2, input bit ng);
    logic [3:0] next_trig;
    bit win_acc, flush, go_old;
    next_trig = 4'b0000;
    go_old    = m_game_over;
    win_acc   = (w1 || w2) && (!m_game_over || ng);
    flush     = win_acc || ng;
    if (cyc >= m_free) begin
      if (m_win_valid) begin
        next_trig    = m_win_id ? 4'b1000 : 4'b0100;
        m_last_issue = cyc + 1;
        m_free       = cyc + 2 + WIN_HOLD;
      end else if (mq.size() > 0 && !flush) begin
        next_trig    = mq[0] ? 4'b0010 : 4'b0001;
        m_last_issue = cyc + 1;
        m_free       = cyc + 2 + GOAL_HOLD;
      end
    end
    if (m_trig[1:0] != 0 && !flush && mq.size() > 0) void'(mq.pop_front());
    if (m_trig[3:2] != 0) m_win_valid = 0;
    if (flush) mq.delete();
    if (ng) begin
      m_game_over = 0;
      m_overflow  = 0;
      m_win_valid = 0;
    end
    if (win_acc) begin
      m_win_valid = 1;
      m_win_id    = !w1;
      m_game_over = 1;
    end
    if (!go_old && !win_acc) begin
      if (g1) begin if (mq.size() == DEPTH) m_overflow = 1; else mq.push_back(1'b0); end
      if (g2) begin if (mq.size() == DEPTH) m_overflow = 1; else mq.push_back(1'b1); end
    end
    m_trig = next_trig;
  endtask

  // One clock cycle: compare this cycle's outputs, drive pulses, step model, advance.
  task automatic applyStimulus(input bit g1, input bit g2, input bit w1, input bit w2, input bit ng);
    logic [3:0] dut_trig;
    dut_trig = {bus.win_player_2, bus.win_player_1, bus.goal_player_2, bus.goal_player_1};
    checkOutput("trig", 32'(dut_trig), 32'(m_trig));
    checkOutput("busy", 32'(bus.busy), 32'((cyc > m_last_issue) && (cyc < m_free)));
    checkOutput("queue_count", 32'(bus.queue_count), 32'(mq.size()));
    checkOutput("overflow", 32'(bus.overflow), 32'(m_overflow));
    checkOutput("game_over", 32'(bus.game_over), 32'(m_game_over));
    if (dut_trig != 4'b0000) begin
      trig_cyc.push_back(cyc);
      trig_kind.push_back(dut_trig);
    end
    if (int'(bus.queue_count) > max_count) max_count = int'(bus.queue_count);
    bus.goal_in_1 = g1;
    bus.goal_in_2 = g2;
    bus.win_in_1  = w1;
    bus.win_in_2  = w2;
    bus.new_game  = ng;
    modelStep(g1, g2, w1, w2, ng);
    @(posedge BALL_CLOCK);
    @(negedge BALL_CLOCK);
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic clearLog();
    trig_cyc.delete();
    trig_kind.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {20'd0, bus.goal_player_1, bus.goal_player_2, bus.win_player_1,
                      bus.win_player_2, bus.busy, bus.queue_count, bus.overflow, bus.game_over}, 32'd0);
  endtask

  initial begin
    int s;
    reset         = 1'b1;
    bus.goal_in_1 = 0;
    bus.goal_in_2 = 0;
    bus.win_in_1  = 0;
    bus.win_in_2  = 0;
    bus.new_game  = 0;
    modelReset();
    #1;
    checkAllZero("reset_outputs");
    @(negedge BALL_CLOCK);
    @(negedge BALL_CLOCK);
    reset = 1'b0;
    idleCycles(4);

    // Single goal from player 2
    clearLog();
    s = cyc;
    applyStimulus(0, 1, 0, 0, 0);
    idleCycles(70);
    checkOutput("single_count", 32'(trig_cyc.size()), 32'd1);
    if (trig_cyc.size() == 1) begin
      checkOutput("single_time", 32'(trig_cyc[0]), 32'(s + 2));
      checkOutput("single_kind", 32'(trig_kind[0]), 32'b0010);
    end

    // Burst of six goals overflowing the queue
    clearLog();
    max_count = 0;
    s = cyc;
    repeat (6) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("burst_overflow", 32'(bus.overflow), 32'd1);
    idleCycles(5 * GAP + 10);
    checkOutput("burst_max_count", 32'(max_count), 32'(DEPTH));
    checkOutput("burst_triggers", 32'(trig_cyc.size()), 32'd5);
    if (trig_cyc.size() == 5) begin
      checkOutput("burst_first", 32'(trig_cyc[0]), 32'(s + 2));
      for (int i = 1; i < 5; i++) begin
        checkOutput("burst_gap", 32'(trig_cyc[i] - trig_cyc[i-1]), 32'(GAP));
        checkOutput("burst_kind", 32'(trig_kind[i]), 32'b0001);
      end
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("burst_overflow_cleared", 32'(bus.overflow), 32'd0);

    // Simultaneous goals in one idle cycle
    clearLog();
    idleCycles(3);
    s = cyc;
    applyStimulus(1, 1, 0, 0, 0);
    idleCycles(2 * GAP + 10);
    checkOutput("simul_triggers", 32'(trig_cyc.size()), 32'd2);
    if (trig_cyc.size() == 2) begin
      checkOutput("simul_first", 32'(trig_kind[0]), 32'b0001);
      checkOutput("simul_second", 32'(trig_kind[1]), 32'b0010);
      checkOutput("simul_gap", 32'(trig_cyc[1] - trig_cyc[0]), 32'(GAP));
    end

    // Win preempts queued goals
    clearLog();
    s = cyc;
    applyStimulus(1, 0, 0, 0, 0);
    idleCycles(5);
    repeat (3) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("preempt_queued", 32'(bus.queue_count), 32'd3);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("preempt_flush", 32'(bus.queue_count), 32'd0);
    checkOutput("preempt_game_over", 32'(bus.game_over), 32'd1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("preempt_goal_ignored", 32'(bus.queue_count), 32'd0);
    idleCycles(GAP + WIN_HOLD + 10);
    checkOutput("preempt_triggers", 32'(trig_cyc.size()), 32'd2);
    if (trig_cyc.size() == 2) begin
      checkOutput("preempt_win_kind", 32'(trig_kind[1]), 32'b1000);
      checkOutput("preempt_win_time", 32'(trig_cyc[1]), 32'(s + 2 + GAP));
    end

    // New game re-enables goals
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("newgame_game_over", 32'(bus.game_over), 32'd0);
    checkOutput("newgame_overflow", 32'(bus.overflow), 32'd0);
    clearLog();
    s = cyc;
    applyStimulus(1, 0, 0, 0, 0);
    idleCycles(GAP + 5);
    checkOutput("newgame_triggers", 32'(trig_cyc.size()), 32'd1);
    if (trig_cyc.size() == 1) checkOutput("newgame_time", 32'(trig_cyc[0]), 32'(s + 2));

    // Reset in the middle of a goal hold
    s = cyc;
    applyStimulus(1, 0, 0, 0, 0);
    idleCycles(11);
    checkOutput("midhold_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    checkAllZero("midhold_reset_outputs");
    @(posedge BALL_CLOCK);
    @(negedge BALL_CLOCK);
    reset = 1'b0;
    modelReset();
    cyc++;
    clearLog();
    idleCycles(GAP + 20);
    checkOutput("midhold_no_trigger", 32'(trig_cyc.size()), 32'd0);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 399) == 0, $urandom_range(0, 399) == 0,
                    $urandom_range(0, 249) == 0);
    end
    idleCycles(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
